// File: rtl/fifo_rd_ctrl_if.sv
// Read-side bus of the async FIFO: memory read port plus the consumer valid/ready stream.
// The controller side is master; the memory/consumer side is slave.
interface fifo_rd_ctrl_if #(
    parameter int unsigned AddrWidth = 3,
    parameter int unsigned DataWidth = 8
);
    logic [AddrWidth-1:0] rd_addr_o;
    logic [DataWidth-1:0] mem_rdata_i;
    logic [DataWidth-1:0] data_o;
    logic                 valid_o;
    logic                 ready_i;

    modport master (
        output rd_addr_o,
        output data_o,
        output valid_o,
        input  mem_rdata_i,
        input  ready_i
    );

    modport slave (
        input  rd_addr_o,
        input  data_o,
        input  valid_o,
        output mem_rdata_i,
        output ready_i
    );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: write-pointer synchronizer, empty/level flags,
// read pointer (binary + Gray) and a first-word-fall-through output register.
module fifo_rd_ctrl #(
    parameter int unsigned AddrWidth      = 3,
    parameter int unsigned DataWidth      = 8,
    parameter int unsigned AlmostEmptyThr = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth:0]   wr_gray_ptr_i,
    fifo_rd_ctrl_if.master       bus,
    output logic [AddrWidth:0]   rd_gray_ptr_o,
    output logic                 empty_o,
    output logic                 almost_empty_o,
    output logic [AddrWidth:0]   level_o
);
    localparam int unsigned PtrW  = AddrWidth + 1;
    localparam int unsigned Depth = 1 << AddrWidth;
    // Thresholds above the depth behave like the depth, so the compare never truncates.
    localparam logic [PtrW-1:0] ThrLevel =
        PtrW'((AlmostEmptyThr > Depth) ? Depth : AlmostEmptyThr);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    out_state_e           state_reg;
    out_state_e           state_next;
    logic [PtrW-1:0]      wq1_reg;
    logic [PtrW-1:0]      wq2_reg;
    logic [PtrW-1:0]      rd_bin_reg;
    logic [PtrW-1:0]      rd_gray_reg;
    logic [DataWidth-1:0] data_reg;
    logic [PtrW-1:0]      wbin;
    logic [PtrW-1:0]      rd_bin_next;
    logic [PtrW-1:0]      rd_gray_next;
    logic                 empty;
    logic                 valid;
    logic                 fetch;

    // Each binary bit is the XOR of all Gray bits at or above it.
    generate
        for (genvar gi = 0; gi < PtrW; gi++) begin : g_gray2bin
            assign wbin[gi] = ^wq2_reg[PtrW-1:gi];
        end
    endgenerate

    assign empty        = (rd_gray_reg == wq2_reg);
    assign rd_bin_next  = rd_bin_reg + 1'b1;
    assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);

    // Output stage FSM: state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= OUT_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output stage FSM: next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            OUT_EMPTY: if (!empty) state_next = OUT_FULL;
            OUT_FULL:  if (bus.ready_i && empty) state_next = OUT_EMPTY;
            default:   state_next = OUT_EMPTY;
        endcase
    end

    // Output stage FSM: outputs.
    always_comb begin
        valid = (state_reg == OUT_FULL);
        fetch = !empty && (!valid || bus.ready_i);
    end

    // No logic in front of wq1_reg: it is the metastability-catching flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wq1_reg <= '0;
            wq2_reg <= '0;
        end else begin
            wq1_reg <= wr_gray_ptr_i;
            wq2_reg <= wq1_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_bin_reg  <= '0;
            rd_gray_reg <= '0;
            data_reg    <= '0;
        end else if (fetch) begin
            rd_bin_reg  <= rd_bin_next;
            rd_gray_reg <= rd_gray_next;
            data_reg    <= bus.mem_rdata_i;
        end
    end

    assign bus.rd_addr_o  = rd_bin_reg[AddrWidth-1:0];
    assign bus.data_o     = data_reg;
    assign bus.valid_o    = valid;
    assign rd_gray_ptr_o  = rd_gray_reg;
    assign empty_o        = empty;
    assign level_o        = wbin - rd_bin_reg;
    assign almost_empty_o = (level_o <= ThrLevel);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (AddrWidth=3, DataWidth=8, AlmostEmptyThr=1).
module tb_fifo_rd_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] wr_gray;
    logic [3:0] rd_gray;
    logic       empty;
    logic       aempty;
    logic [3:0] level;
    logic [7:0] mem [8];
    int         checks = 0;
    int         errors = 0;

    fifo_rd_ctrl_if #(.AddrWidth(3), .DataWidth(8)) bus ();

    assign bus.mem_rdata_i = mem[bus.rd_addr_o];

    fifo_rd_ctrl #(
        .AddrWidth      (3),
        .DataWidth      (8),
        .AlmostEmptyThr (1)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_gray_ptr_i  (wr_gray),
        .bus            (bus),
        .rd_gray_ptr_o  (rd_gray),
        .empty_o        (empty),
        .almost_empty_o (aempty),
        .level_o        (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        wr_gray     = 4'b0000;
        bus.ready_i = 1'b0;
        step(2);
        rst = 1'b0;
    endtask

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        int         wcount;
        int         rcount;
        logic [3:0] prev_gray;

        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        // Reset with a non-zero write pointer present
        rst         = 1'b1;
        wr_gray     = 4'b0110;
        bus.ready_i = 1'b0;
        step(2);
        check("rst_valid", bus.valid_o, 1'b0);
        check("rst_data", bus.data_o, 8'h00);
        check("rst_addr", bus.rd_addr_o, 3'd0);
        check("rst_gray", rd_gray, 4'd0);
        check("rst_level", level, 4'd0);
        check("rst_empty", empty, 1'b1);
        check("rst_aempty", aempty, 1'b1);
        rst = 1'b0;
        step(1);
        check("sync1_empty", empty, 1'b1);
        check("sync1_level", level, 4'd0);
        step(1);
        check("sync2_empty", empty, 1'b0);
        check("sync2_level", level, 4'd4);
        check("sync2_valid", bus.valid_o, 1'b0);
        $display("reset: wq2 loaded two edges after release, level %0d", level);

        // Single word, 3-edge latency
        do_reset();
        mem[0]  = 8'hA5;
        wr_gray = 4'b0001;
        step(1);
        check("sw_e0_valid", bus.valid_o, 1'b0);
        check("sw_e0_empty", empty, 1'b1);
        step(1);
        check("sw_e1_empty", empty, 1'b0);
        check("sw_e1_level", level, 4'd1);
        check("sw_e1_valid", bus.valid_o, 1'b0);
        step(1);
        check("sw_valid", bus.valid_o, 1'b1);
        check("sw_data", bus.data_o, 8'hA5);
        check("sw_gray", rd_gray, 4'd1);
        check("sw_empty", empty, 1'b1);
        check("sw_level", level, 4'd0);
        check("sw_addr", bus.rd_addr_o, 3'd1);
        $display("single: data %h gray %b", bus.data_o, rd_gray);

        // Backpressure: 3 words, consumer stalled for 10 cycles
        do_reset();
        mem[0]  = 8'h11;
        mem[1]  = 8'h22;
        mem[2]  = 8'h33;
        wr_gray = 4'b0010;
        step(3);
        check("bp_valid", bus.valid_o, 1'b1);
        check("bp_data", bus.data_o, 8'h11);
        check("bp_level", level, 4'd2);
        check("bp_gray", rd_gray, 4'd1);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("bp_hold_data", bus.data_o, 8'h11);
            check("bp_hold_valid", bus.valid_o, 1'b1);
            check("bp_hold_gray", rd_gray, 4'd1);
        end
        bus.ready_i = 1'b1;
        step(1);
        check("bp_w2_data", bus.data_o, 8'h22);
        check("bp_w2_valid", bus.valid_o, 1'b1);
        $display("backpressure: word data %h", bus.data_o);
        step(1);
        check("bp_w3_data", bus.data_o, 8'h33);
        check("bp_w3_valid", bus.valid_o, 1'b1);
        check("bp_w3_empty", empty, 1'b1);
        $display("backpressure: word data %h", bus.data_o);
        step(1);
        check("bp_end_valid", bus.valid_o, 1'b0);
        check("bp_end_data", bus.data_o, 8'h33);
        check("bp_end_gray", rd_gray, 4'b0010);

        // Wrap-around: stream 20 words through the 4-bit pointers
        do_reset();
        bus.ready_i = 1'b1;
        wcount      = 0;
        rcount      = 0;
        prev_gray   = 4'b0000;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (wcount < 20) begin
                mem[wcount % 8] = 8'(8'h30 + wcount);
                wcount++;
                wr_gray = bin2gray(4'(wcount));
            end
            step(1);
            if (bus.valid_o) begin
                check("wrap_data", bus.data_o, 8'(8'h30 + rcount));
                rcount++;
                check("wrap_gray", rd_gray, bin2gray(4'(rcount)));
                check("wrap_onebit", $countones(prev_gray ^ rd_gray), 1);
                $display("wrap: word %0d data %h gray %b", rcount, bus.data_o, rd_gray);
                prev_gray = rd_gray;
            end
        end
        check("wrap_count", rcount, 20);
        check("wrap_end_valid", bus.valid_o, 1'b0);
        check("wrap_end_empty", empty, 1'b1);

        // Full: level 8 with read pointer 0
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'hC0 + i);
        wr_gray = 4'b1100;
        step(2);
        check("full_level", level, 4'd8);
        check("full_aempty", aempty, 1'b0);
        check("full_empty", empty, 1'b0);
        check("full_valid", bus.valid_o, 1'b0);
        step(1);
        check("full_w0_valid", bus.valid_o, 1'b1);
        check("full_w0_data", bus.data_o, 8'hC0);
        check("full_w0_level", level, 4'd7);
        $display("full: word 0 data %h", bus.data_o);
        bus.ready_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            step(1);
            check("full_drain_data", bus.data_o, 8'(8'hC0 + i));
            check("full_drain_valid", bus.valid_o, 1'b1);
            $display("full: word %0d data %h", i, bus.data_o);
        end
        step(1);
        check("full_end_valid", bus.valid_o, 1'b0);
        check("full_end_empty", empty, 1'b1);
        check("full_end_level", level, 4'd0);
        check("full_end_gray", rd_gray, 4'b1100);

        // Reset mid-stream
        do_reset();
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'h50 + i);
        wr_gray = 4'b0110;
        step(3);
        check("mid_pre_valid", bus.valid_o, 1'b1);
        check("mid_pre_level", level, 4'd3);
        rst     = 1'b1;
        wr_gray = 4'b0000;
        step(1);
        rst = 1'b0;
        check("mid_valid", bus.valid_o, 1'b0);
        check("mid_addr", bus.rd_addr_o, 3'd0);
        check("mid_gray", rd_gray, 4'd0);
        check("mid_level", level, 4'd0);
        check("mid_empty", empty, 1'b1);
        check("mid_data", bus.data_o, 8'h00);
        $display("midreset: valid %0d level %0d", bus.valid_o, level);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
